// File: rtl/crack_host_sequencer.sv
// -----------------------------------------------------------------------------
// crack_host_sequencer
//
// Host-side sequencer for a shared-bus password cracker. It loads NUM_HASHES
// 128-bit target hashes into the cracker one byte at a time, starts a run,
// and then reads back each cracked password plus its length byte. Every
// recovered password is presented on a valid/ready result port. The session
// ends when the cracker reports a turn with no further match.
//
// The cracker and the host share a bus. The host acts only when my_turn is
// high. Every strobe and go the host issues is exactly two cycles wide and is
// followed by one idle cycle.
//
// Ports
//   clk              in   1            sole clock, rising edge
//   rst_n            in   1            synchronous active-low reset
//   start            in   1            one-cycle session request (IDLE only)
//   hash_in          in   128          hash word from the upstream source
//   hash_valid       in   1            upstream hash word valid
//   hash_ready       out  1            sequencer can accept a hash word
//   new_hash_byte    out  8            hash byte presented to the cracker
//   store_hash_byte  out  1            two-cycle strobe storing new_hash_byte
//   go               out  1            two-cycle run/advance pulse
//   match_found      in   1            cracker found a password (on my_turn)
//   my_turn          in   1            cracker yields the bus to the host
//   password_byte    in   8            password / length byte from cracker
//   result_password  out  8*PW_BYTES   recovered password, first byte in MSBs
//   result_length    out  8            recovered password length
//   result_valid     out  1            result port holds a password
//   result_ready     in   1            downstream accepts the result
//   found_count      out  8            passwords delivered this session (sat.)
//   busy             out  1            high whenever not IDLE
//   done             out  1            one-cycle end-of-session flag
// -----------------------------------------------------------------------------
module crack_host_sequencer #(
   parameter int NUM_HASHES = 2,
   parameter int PW_BYTES   = 20
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [127:0]          hash_in,
   input  logic                  hash_valid,
   output logic                  hash_ready,
   output logic [7:0]            new_hash_byte,
   output logic                  store_hash_byte,
   output logic                  go,
   input  logic                  match_found,
   input  logic                  my_turn,
   input  logic [7:0]            password_byte,
   output logic [8*PW_BYTES-1:0] result_password,
   output logic [7:0]            result_length,
   output logic                  result_valid,
   input  logic                  result_ready,
   output logic [7:0]            found_count,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [3:0] {
      IDLE,
      WAIT_HASH,
      HB_TURN,
      HB_SETUP,
      HB_STROBE,
      HB_RELEASE,
      GO_TURN,
      GO_PULSE,
      RUN_WAIT,
      PW_TURN,
      PW_GO,
      RESULT,
      DONE
   } state_t;

   localparam logic [4:0] PW_LAST  = 5'(PW_BYTES);
   localparam logic [7:0] HASH_NUM = 8'(NUM_HASHES);

   state_t                state, state_next;
   logic [127:0]          hash_reg;
   logic [3:0]            byte_idx;
   logic [7:0]            hash_cnt;
   logic [4:0]            pw_idx;
   logic [1:0]            phase;
   logic [8*PW_BYTES-1:0] pw_reg;
   logic [7:0]            len_reg;
   logic [7:0]            found_reg;

   // State register. Reset is synchronous, so a reset that arrives during a
   // strobe or a pending result still takes effect on the next edge.
   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state logic. A two-cycle pulse uses phases 0 and 1. A go pulse adds
   // a third, low phase (2) before the bus is handed back. A hash-byte strobe
   // hands its idle cycle to HB_RELEASE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:       if (start) state_next = WAIT_HASH;
         WAIT_HASH:  if (hash_valid) state_next = HB_TURN;
         HB_TURN:    if (my_turn) state_next = HB_SETUP;
         HB_SETUP:   state_next = HB_STROBE;
         HB_STROBE:  if (phase == 2'd1) state_next = HB_RELEASE;
         HB_RELEASE: begin
            if (byte_idx != 4'd15)
               state_next = HB_TURN;
            else if (hash_cnt < HASH_NUM)
               state_next = WAIT_HASH;
            else
               state_next = GO_TURN;
         end
         GO_TURN:    if (my_turn) state_next = GO_PULSE;
         GO_PULSE:   if (phase == 2'd2) state_next = RUN_WAIT;
         RUN_WAIT: begin
            if (my_turn)
               state_next = match_found ? PW_TURN : DONE;
         end
         PW_TURN:    if (my_turn) state_next = PW_GO;
         PW_GO: begin
            if (phase == 2'd2)
               state_next = (pw_idx < PW_LAST) ? PW_TURN : RESULT;
         end
         RESULT:     if (result_ready) state_next = RUN_WAIT;
         DONE:       state_next = IDLE;
         default:    state_next = IDLE;
      endcase
   end

   // Output logic. Every control output depends only on registered state. RESULT
   // drives neither go nor store_hash_byte, so a stalled result cannot disturb
   // the cracker.
   always_comb begin
      busy            = (state != IDLE);
      hash_ready      = (state == WAIT_HASH);
      store_hash_byte = (state == HB_STROBE);
      go              = ((state == GO_PULSE) || (state == PW_GO)) && (phase != 2'd2);
      result_valid    = (state == RESULT);
      done            = (state == DONE);
      new_hash_byte   = 8'h00;
      if ((state == HB_SETUP) || (state == HB_STROBE) || (state == HB_RELEASE))
         new_hash_byte = hash_reg[{byte_idx, 3'b000} +: 8];
      result_password = pw_reg;
      result_length   = len_reg;
      found_count     = found_reg;
   end

   // Datapath registers: hash latch, byte and hash counters, pulse phase,
   // password assembly and the found counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hash_reg  <= '0;
         byte_idx  <= '0;
         hash_cnt  <= '0;
         pw_idx    <= '0;
         phase     <= '0;
         pw_reg    <= '0;
         len_reg   <= '0;
         found_reg <= '0;
      end else begin
         // The phase counts only while a pulse state is held. It restarts at
         // zero on every state change.
         if (((state == HB_STROBE) || (state == GO_PULSE) || (state == PW_GO)) &&
             (state_next == state))
            phase <= phase + 2'd1;
         else
            phase <= 2'd0;

         case (state)
            IDLE: begin
               if (start) begin
                  found_reg <= '0;
                  hash_cnt  <= '0;
               end
            end
            WAIT_HASH: begin
               if (hash_valid) begin
                  hash_reg <= hash_in;
                  byte_idx <= 4'd0;
                  if (hash_cnt != 8'hFF)
                     hash_cnt <= hash_cnt + 8'd1;
               end
            end
            HB_RELEASE: begin
               if (byte_idx != 4'd15)
                  byte_idx <= byte_idx + 4'd1;
            end
            RUN_WAIT: begin
               if (my_turn && match_found)
                  pw_idx <= 5'd0;
            end
            PW_TURN: begin
               // The first password byte lands in the most significant byte.
               // The extra byte after the password is its length.
               if (my_turn) begin
                  for (int k = 0; k < PW_BYTES; k++) begin
                     if (pw_idx == 5'(k))
                        pw_reg[8*(PW_BYTES-1-k) +: 8] <= password_byte;
                  end
                  if (pw_idx == PW_LAST)
                     len_reg <= password_byte;
               end
            end
            PW_GO: begin
               if ((phase == 2'd2) && (pw_idx < PW_LAST))
                  pw_idx <= pw_idx + 5'd1;
            end
            RESULT: begin
               if (result_ready && (found_reg != 8'hFF))
                  found_reg <= found_reg + 8'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_crack_host_sequencer.sv
// -----------------------------------------------------------------------------
// tb_crack_host_sequencer
//
// Directed bench for crack_host_sequencer. A small cracker model supplies the
// password bytes, and a monitor measures strobe and go pulses. The main
// sequence loads two hashes, recovers one password, stalls the result, ends
// the session, and then resets in the middle of a strobe.
// -----------------------------------------------------------------------------
module tb_crack_host_sequencer;

   localparam int PW_BYTES = 20;
   localparam logic [127:0] H0 = 128'h588FEB889288FB953B5F094D47D1565C;
   localparam logic [127:0] H1 = 128'h91D533DC611AC2774431E2D0BAF36805;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  start;
   logic [127:0]          hash_in;
   logic                  hash_valid;
   logic                  hash_ready;
   logic [7:0]            new_hash_byte;
   logic                  store_hash_byte;
   logic                  go;
   logic                  match_found;
   logic                  my_turn;
   logic [7:0]            password_byte;
   logic [8*PW_BYTES-1:0] result_password;
   logic [7:0]            result_length;
   logic                  result_valid;
   logic                  result_ready;
   logic [7:0]            found_count;
   logic                  busy;
   logic                  done;

   int errors = 0;
   int checks = 0;

   // Monitor state
   int          strobe_run = 0;
   int          go_run = 0;
   int          strobe_count = 0;
   int          go_pulses = 0;
   int          bad_strobe_len = 0;
   int          bad_go_len = 0;
   int          byte_changed = 0;
   int          overlap = 0;
   logic [7:0]  strobe_byte = 8'h00;
   logic [7:0]  byte_q[$];

   // Cracker model: 0x31, 0x32, 18 zero bytes, then length 0x02.
   logic [7:0] pw_table [0:20];
   int         pw_sel;

   crack_host_sequencer #(.NUM_HASHES(2), .PW_BYTES(PW_BYTES)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .hash_in         (hash_in),
      .hash_valid      (hash_valid),
      .hash_ready      (hash_ready),
      .new_hash_byte   (new_hash_byte),
      .store_hash_byte (store_hash_byte),
      .go              (go),
      .match_found     (match_found),
      .my_turn         (my_turn),
      .password_byte   (password_byte),
      .result_password (result_password),
      .result_length   (result_length),
      .result_valid    (result_valid),
      .result_ready    (result_ready),
      .found_count     (found_count),
      .busy            (busy),
      .done            (done)
   );

   always #5 clk = ~clk;

   // Pulse 1 is the run start. The byte for password index j is therefore
   // presented after pulse j+1.
   assign pw_sel = (go_pulses == 0) ? 0 : ((go_pulses - 1 > 20) ? 20 : go_pulses - 1);
   assign password_byte = (go_pulses - 1 > 20) ? 8'h00 : pw_table[pw_sel];

   initial begin
      for (int i = 0; i <= 20; i++) pw_table[i] = 8'h00;
      pw_table[0]  = 8'h31;
      pw_table[1]  = 8'h32;
      pw_table[20] = 8'h02;
   end

   // Pulse monitor, sampled on the falling edge. It measures strobe and go
   // widths, the byte held across each strobe, and any go/strobe overlap.
   always @(negedge clk) begin
      if (go && store_hash_byte) overlap++;
      if (store_hash_byte) begin
         strobe_run++;
         if (strobe_run == 1) strobe_byte = new_hash_byte;
         else if (new_hash_byte !== strobe_byte) byte_changed++;
      end else if (strobe_run > 0) begin
         if (strobe_run != 2) bad_strobe_len++;
         if (new_hash_byte !== strobe_byte) byte_changed++;
         byte_q.push_back(strobe_byte);
         strobe_count++;
         strobe_run = 0;
      end
      if (go) begin
         go_run++;
      end else if (go_run > 0) begin
         if (go_run != 2) bad_go_len++;
         go_pulses++;
         go_run = 0;
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic turn, input logic match,
                                input logic ready, input int cycles);
      my_turn      = turn;
      match_found  = match;
      result_ready = ready;
      for (int i = 0; i < cycles; i++) tick();
   endtask

   task automatic checkOutput(input string tag, input logic [159:0] observed,
                              input logic [159:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   logic [127:0] hsh;
   logic [159:0] pw_exp;

   initial begin
      rst_n = 1'b0; start = 1'b0; hash_in = '0; hash_valid = 1'b0;
      my_turn = 1'b0; match_found = 1'b0; result_ready = 1'b0;
      pw_exp = {8'h31, 8'h32, 144'h0};

      // Reset state
      applyStimulus(1'b0, 1'b0, 1'b0, 4);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_hash_ready", hash_ready, 1'b0);
      checkOutput("rst_store", store_hash_byte, 1'b0);
      checkOutput("rst_go", go, 1'b0);
      checkOutput("rst_done", done, 1'b0);
      checkOutput("rst_result_valid", result_valid, 1'b0);
      checkOutput("rst_found_count", found_count, 8'h00);
      checkOutput("rst_result_password", result_password, '0);

      // Start the session with my_turn low.
      rst_n = 1'b1;
      tick();
      checkOutput("idle_busy", busy, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("wait_hash_busy", busy, 1'b1);
      checkOutput("wait_hash_ready", hash_ready, 1'b1);
      checkOutput("wait_hash_found_clr", found_count, 8'h00);

      hash_in = H0; hash_valid = 1'b1;
      tick();
      hash_valid = 1'b0;
      checkOutput("hb_turn_ready_low", hash_ready, 1'b0);

      // Pulse start while busy. The session must not restart.
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      checkOutput("busy_start_no_restart", hash_ready, 1'b0);
      checkOutput("busy_start_busy", busy, 1'b1);

      // Hold my_turn low for 50 cycles. No strobe may appear.
      applyStimulus(1'b0, 1'b1, 1'b0, 50);
      checkOutput("no_strobe_while_not_turn", strobe_count, 0);
      checkOutput("store_low_while_not_turn", store_hash_byte, 1'b0);

      // Release the bus and wait for the second hash request.
      my_turn = 1'b1;
      for (int n = 0; n < 200 && !hash_ready; n++) tick();
      checkOutput("wait_second_hash_ready", hash_ready, 1'b1);
      checkOutput("first_hash_strobes", strobe_count, 16);
      hash_in = H1; hash_valid = 1'b1;
      tick();
      hash_valid = 1'b0;

      // Wait for the run-start go pulse.
      for (int n = 0; n < 200 && go_pulses < 1; n++) tick();
      checkOutput("run_go_pulses", go_pulses, 1);
      checkOutput("total_strobes", strobe_count, 32);
      checkOutput("strobe_width", bad_strobe_len, 0);
      checkOutput("strobe_byte_stable", byte_changed, 0);
      checkOutput("byte0_h0", byte_q[0], 8'h5C);
      checkOutput("byte1_h0", byte_q[1], 8'h56);
      checkOutput("byte15_h0", byte_q[15], 8'h58);
      checkOutput("byte16_h1", byte_q[16], 8'h05);
      checkOutput("byte31_h1", byte_q[31], 8'h91);
      for (int k = 0; k < 32; k++) begin
         hsh = (k < 16) ? H0 : H1;
         hsh = hsh >> (8 * (k % 16));
         checkOutput($sformatf("hash_byte_%0d", k), byte_q[k], hsh[7:0]);
      end

      // Password read-back. match_found is already high.
      for (int n = 0; n < 300 && !result_valid; n++) tick();
      checkOutput("result_valid_rise", result_valid, 1'b1);
      checkOutput("result_password", result_password, pw_exp);
      checkOutput("result_length", result_length, 8'h02);
      checkOutput("total_go_pulses", go_pulses, 22);
      checkOutput("go_width", bad_go_len, 0);
      checkOutput("found_before_ready", found_count, 8'h00);

      // Stall the result for 10 cycles with my_turn high.
      match_found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         checkOutput("stall_valid", result_valid, 1'b1);
         checkOutput("stall_go", go, 1'b0);
         checkOutput("stall_store", store_hash_byte, 1'b0);
         checkOutput("stall_password", result_password, pw_exp);
         checkOutput("stall_length", result_length, 8'h02);
         checkOutput("stall_found", found_count, 8'h00);
      end

      // Accept the result, then the no-match turn ends the session.
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      checkOutput("accept_valid_low", result_valid, 1'b0);
      checkOutput("accept_found_count", found_count, 8'h01);
      tick();
      checkOutput("done_high", done, 1'b1);
      checkOutput("done_busy", busy, 1'b1);
      tick();
      checkOutput("done_one_cycle", done, 1'b0);
      checkOutput("idle_after_done", busy, 1'b0);
      checkOutput("found_retained", found_count, 8'h01);
      checkOutput("go_pulses_final", go_pulses, 22);
      checkOutput("no_go_store_overlap", overlap, 0);
      tick();
      checkOutput("done_stays_low", done, 1'b0);

      // New session: start clears found_count. Then reset during the
      // second strobe cycle.
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("restart_found_clr", found_count, 8'h00);
      checkOutput("restart_hash_ready", hash_ready, 1'b1);
      hash_in = H1; hash_valid = 1'b1;
      tick();
      hash_valid = 1'b0;
      for (int n = 0; n < 20 && !store_hash_byte; n++) tick();
      checkOutput("strobe_first_cycle", store_hash_byte, 1'b1);
      tick();
      checkOutput("strobe_second_cycle", store_hash_byte, 1'b1);
      checkOutput("strobe_second_byte", new_hash_byte, 8'h05);
      rst_n = 1'b0; start = 1'b1; hash_valid = 1'b1;
      tick();
      checkOutput("mid_rst_store", store_hash_byte, 1'b0);
      checkOutput("mid_rst_busy", busy, 1'b0);
      checkOutput("mid_rst_byte", new_hash_byte, 8'h00);
      checkOutput("mid_rst_hash_ready", hash_ready, 1'b0);
      checkOutput("mid_rst_go", go, 1'b0);
      checkOutput("mid_rst_found", found_count, 8'h00);
      checkOutput("mid_rst_password", result_password, '0);
      checkOutput("mid_rst_length", result_length, 8'h00);
      tick();
      checkOutput("rst_held_start_ignored", busy, 1'b0);
      rst_n = 1'b1; start = 1'b0; hash_valid = 1'b0;
      tick();
      checkOutput("post_rst_idle", busy, 1'b0);
      checkOutput("post_rst_hash_ready", hash_ready, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/crack_host_sequencer.md
CRACK_HOST_SEQUENCER -- requirements
Module: crack_host_sequencer

Interface
REQ-001 SHALL have parameter NUM_HASHES, default 2, number of 128-bit hashes loaded per session (1..255).
REQ-002 SHALL have parameter PW_BYTES, default 20, number of password bytes read per match; a length byte follows them.
REQ-003 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  in  1  synchronous active-low reset.
REQ-005 SHALL have port start  in  1  one-cycle request to begin a session.
REQ-006 SHALL have ports hash_in  in  128, hash_valid  in  1, hash_ready  out  1: upstream hash source, valid/ready handshake.
REQ-007 SHALL have ports new_hash_byte  out  8, store_hash_byte  out  1, go  out  1: drive the cracker.
REQ-008 SHALL have ports match_found  in  1, my_turn  in  1, password_byte  in  8: status and data from the cracker.
REQ-009 SHALL have ports result_password  out  8*PW_BYTES, result_length  out  8, result_valid  out  1, result_ready  in  1: result handshake.
REQ-010 SHALL have ports found_count  out  8, busy  out  1, done  out  1.

Function
REQ-011 States SHALL be IDLE, WAIT_HASH, HB_TURN, HB_SETUP, HB_STROBE, HB_RELEASE, GO_TURN, GO_PULSE, RUN_WAIT, PW_TURN, PW_GO, RESULT, DONE.
REQ-012 IDLE: busy=0; start=1 -> WAIT_HASH, clear found_count and the hash counter; start ignored in every other state.
REQ-013 WAIT_HASH: hash_ready=1; on hash_valid&hash_ready, latch hash_in, byte index=0 -> HB_TURN; hash_ready=0 in all other states.
REQ-014 HB_TURN: wait until my_turn=1 -> HB_SETUP.
REQ-015 HB_SETUP: new_hash_byte=hash[8*i+7:8*i], least significant byte first (i=0..15), for one cycle before strobe.
REQ-016 HB_STROBE: store_hash_byte=1 for exactly 2 cycles; new_hash_byte held stable.
REQ-017 HB_RELEASE: store_hash_byte=0 for one cycle, byte still stable; then i<15 -> i+1, HB_TURN; i=15 and hash count<NUM_HASHES -> WAIT_HASH; else GO_TURN.
REQ-018 GO_TURN waits for my_turn=1; GO_PULSE drives go=1 for exactly 2 cycles, then one cycle go=0, then RUN_WAIT.
REQ-019 RUN_WAIT: match_found sampled only when my_turn=1; my_turn&match_found -> PW_TURN with byte index j=0; my_turn&!match_found -> DONE.
REQ-020 PW_TURN: on my_turn=1 capture password_byte; j<PW_BYTES stores into result_password[8*(PW_BYTES-1-j)+7 -: 8] (first byte most significant); j=PW_BYTES stores into result_length; -> PW_GO.
REQ-021 PW_GO: go=1 for 2 cycles, go=0 one cycle; j<PW_BYTES -> j+1, PW_TURN; else RESULT.
REQ-022 RESULT: result_valid=1, result data stable; on result_ready -> found_count+1 (saturating at 255), result_valid=0 next cycle, -> RUN_WAIT.
REQ-023 While result_valid=1 and result_ready=0 the block SHALL drive no go/store_hash_byte and ignore my_turn.
REQ-024 DONE: done=1 for exactly one cycle -> IDLE; found_count retained until next start.
REQ-025 busy=1 in every state except IDLE; go and store_hash_byte SHALL never be high simultaneously.
REQ-026 Counters: byte index 4 bits, hash counter 8 bits, password index 5 bits; no wrap beyond stated ranges.

Reset
REQ-027 rst_n=0 at a clock edge SHALL force IDLE and zero every output and internal register on that edge, including mid-strobe or mid-result.
REQ-028 start, hash_valid and my_turn SHALL be ignored while rst_n=0.

Verification
REQ-029 Load 128'h588FEB889288FB953B5F094D47D1565C then 128'h91D533DC611AC2774431E2D0BAF36805, my_turn=1 -> bytes 5C,56,D1,47,...,58 then 05,68,F3,...,91; 32 two-cycle strobes; then one two-cycle go.
REQ-030 Cracker model asserts my_turn&match_found, supplies 0x31,0x32, 18x 0x00, length 0x02 -> result_password=0x3132 followed by 18 zero bytes, result_length=2, 21 go pulses, found_count=1 after result_ready.
REQ-031 Hold result_ready=0 for 10 cycles with my_turn=1 -> result_valid and data stable, go=0 throughout, found_count unchanged.
REQ-032 In RUN_WAIT assert my_turn=1, match_found=0 -> done high exactly one cycle, busy=0 next cycle, found_count retained.
REQ-033 Drop rst_n during second HB_STROBE cycle -> store_hash_byte=0 next cycle, all outputs 0, state IDLE; start pulsed during reset ignored.
REQ-034 Pulse start while busy, and hold my_turn=0 in HB_TURN for 50 cycles -> no session restart, no strobe until my_turn rises.
